// File: rtl/hash_table_pkg.sv
// Shared types and constants for the linear-probing hash table.
// Holds the command, slot-state and FSM enums plus the FNV-1a constants.
package hash_table_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_DELETE = 2'b01,
        OP_SEARCH = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY     = 2'b00,
        SLOT_VALID     = 2'b01,
        SLOT_TOMBSTONE = 2'b10
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HASH  = 2'b01,
        ST_PROBE = 2'b10,
        ST_DONE  = 2'b11
    } fsm_state_e;

    localparam logic [31:0] FNV_BASIS = 32'h811C_9DC5;
    localparam logic [31:0] FNV_PRIME = 32'h0100_0193;

endpackage

// File: rtl/hash_index_gen.sv
// Combinational key -> home-slot index, either key mod TOTAL_ENTRY or
// 32-bit FNV-1a over the key bytes (LSB byte first), truncated to the index width.
module hash_index_gen
    import hash_table_pkg::*;
#(
    parameter int    KEY_WIDTH      = 32,
    parameter int    TOTAL_ENTRY    = 16,
    parameter string HASH_ALGORITHM = "MODULUS",
    localparam int   IDX_W          = $clog2(TOTAL_ENTRY)
) (
    input  logic [KEY_WIDTH-1:0] key,
    output logic [IDX_W-1:0]     index
);

    if (HASH_ALGORITHM == "FNV1A") begin : g_fnv
        localparam int NBYTES = KEY_WIDTH / 8;
        logic [31:0] h;

        always_comb begin
            h = FNV_BASIS;
            for (int b = 0; b < NBYTES; b++) begin
                h = (h ^ {24'd0, key[b*8 +: 8]}) * FNV_PRIME;
            end
        end

        logic unused_hash_hi;
        assign unused_hash_hi = ^h[31:IDX_W];
        assign index = h[IDX_W-1:0];
    end else begin : g_mod
        // TOTAL_ENTRY is a power of two, so the modulus is just the low bits.
        logic unused_key_hi;
        assign unused_key_hi = ^key[KEY_WIDTH-1:IDX_W];
        assign index = key[IDX_W-1:0];
    end

endmodule

// File: rtl/hash_table_lp.sv
// Open-addressing key/value table with linear probing and tombstone deletion.
// Optional statistics outputs are enabled by defining HASH_TABLE_STATS_EN.
module hash_table_lp
    import hash_table_pkg::*;
#(
    parameter int    KEY_WIDTH      = 32,
    parameter int    VALUE_WIDTH    = 32,
    parameter int    TOTAL_ENTRY    = 16,
    parameter int    MAX_PROBE      = TOTAL_ENTRY,
    parameter string HASH_ALGORITHM = "MODULUS",
    localparam int   IDX_W          = $clog2(TOTAL_ENTRY),
    localparam int   CW             = $clog2(MAX_PROBE + 1),
    localparam int   OCC_W          = $clog2(TOTAL_ENTRY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    // A command transfers on a rising edge where op_valid && op_ready; op_ready is
    // high only while idle, and op_valid seen while op_ready is low is dropped.
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [1:0]             op_sel,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    output logic                   op_done,
    output logic                   op_error,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic [CW-1:0]          probe_count,
    output logic [OCC_W-1:0]       occupancy,
`ifdef HASH_TABLE_STATS_EN
    output logic [CW-1:0]          max_probe_seen,
    output logic [15:0]            error_cnt,
`endif
    output fsm_state_e             dbg_state
);

    fsm_state_e state, state_nxt;

    op_e                    op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [IDX_W-1:0]       home_q;
    logic [CW-1:0]          p_q;
    logic                   cand_found_q;
    logic [IDX_W-1:0]       cand_idx_q;
    logic                   err_q;

    slot_state_e            slot_st  [TOTAL_ENTRY];
    logic [KEY_WIDTH-1:0]   slot_key [TOTAL_ENTRY];
    logic [VALUE_WIDTH-1:0] slot_val [TOTAL_ENTRY];

    logic [IDX_W-1:0] hash_idx;

    hash_index_gen #(
        .KEY_WIDTH     (KEY_WIDTH),
        .TOTAL_ENTRY   (TOTAL_ENTRY),
        .HASH_ALGORITHM(HASH_ALGORITHM)
    ) u_hash (
        .key  (key_q),
        .index(hash_idx)
    );

    logic             accept;
    logic [IDX_W-1:0] probe_idx;
    slot_state_e      cur_st;
    logic             hit, slot_empty, last_probe, term;
    logic             free_here, cand_ok;
    logic [IDX_W-1:0] cand_sel;
    logic [CW-1:0]    p_next;

    assign accept = op_valid && (state == ST_IDLE);

    always_comb begin
        probe_idx  = home_q + IDX_W'(p_q);
        cur_st     = slot_st[probe_idx];
        p_next     = p_q + CW'(1);
        hit        = (cur_st == SLOT_VALID) && (slot_key[probe_idx] == key_q);
        slot_empty = (cur_st == SLOT_EMPTY);
        last_probe = (p_next == CW'(MAX_PROBE));
        term       = hit || slot_empty || last_probe;
        // The earliest free slot on the probe path is where a missing key goes.
        free_here  = (cur_st != SLOT_VALID);
        cand_ok    = cand_found_q || free_here;
        cand_sel   = cand_found_q ? cand_idx_q : probe_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (op_e'(op_sel) == OP_CLEAR) ? ST_DONE : ST_HASH;
            ST_HASH:  state_nxt = ST_PROBE;
            ST_PROBE: if (term) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= OP_INSERT;
            key_q        <= '0;
            val_q        <= '0;
            home_q       <= '0;
            p_q          <= '0;
            cand_found_q <= 1'b0;
            cand_idx_q   <= '0;
            err_q        <= 1'b0;
            value_out    <= '0;
            probe_count  <= '0;
            occupancy    <= '0;
`ifdef HASH_TABLE_STATS_EN
            max_probe_seen <= '0;
            error_cnt      <= '0;
`endif
            for (int i = 0; i < TOTAL_ENTRY; i++) begin
                slot_st[i]  <= SLOT_EMPTY;
                slot_key[i] <= '0;
                slot_val[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    op_q        <= op_e'(op_sel);
                    key_q       <= key_in;
                    val_q       <= value_in;
                    value_out   <= '0;
                    probe_count <= '0;
                    err_q       <= 1'b0;
                    if (op_e'(op_sel) == OP_CLEAR) begin
                        occupancy <= '0;
`ifdef HASH_TABLE_STATS_EN
                        max_probe_seen <= '0;
                        error_cnt      <= '0;
`endif
                        for (int i = 0; i < TOTAL_ENTRY; i++) slot_st[i] <= SLOT_EMPTY;
                    end
                end
                ST_HASH: begin
                    home_q       <= hash_idx;
                    p_q          <= '0;
                    cand_found_q <= 1'b0;
                end
                ST_PROBE: if (!term) begin
                    p_q <= p_next;
                    if (!cand_found_q && free_here) begin
                        cand_found_q <= 1'b1;
                        cand_idx_q   <= probe_idx;
                    end
                end else begin
                    probe_count <= p_next;
`ifdef HASH_TABLE_STATS_EN
                    if (p_next > max_probe_seen) max_probe_seen <= p_next;
`endif
                    case (op_q)
                        OP_INSERT: begin
                            if (hit) begin
                                slot_val[probe_idx] <= val_q;
                            end else if (cand_ok) begin
                                slot_st[cand_sel]  <= SLOT_VALID;
                                slot_key[cand_sel] <= key_q;
                                slot_val[cand_sel] <= val_q;
                                occupancy          <= occupancy + OCC_W'(1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            if (hit) begin
                                slot_st[probe_idx]  <= SLOT_TOMBSTONE;
                                slot_key[probe_idx] <= '0;
                                slot_val[probe_idx] <= '0;
                                occupancy           <= occupancy - OCC_W'(1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        OP_SEARCH: begin
                            if (hit) value_out <= slot_val[probe_idx];
                            else     err_q     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_DONE: begin
`ifdef HASH_TABLE_STATS_EN
                    if (err_q && (error_cnt != 16'hFFFF)) error_cnt <= error_cnt + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign op_ready  = (state == ST_IDLE);
    assign op_done   = (state == ST_DONE);
    assign op_error  = op_done && err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_hash_table_lp.sv
// Self-checking bench for hash_table_lp (TOTAL_ENTRY=8, MODULUS hash) against a
// behavioural table model; also covers HASH_TABLE_STATS_EN outputs when defined.
module tb_hash_table_lp;
    import hash_table_pkg::*;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int TE = 8;
    localparam int MP = 8;
    localparam int CW = $clog2(MP + 1);
    localparam int OW = $clog2(TE + 1);
    localparam int EW = 1 + VW + CW + OW + 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op_sel = 2'b00;
    logic [KW-1:0] key_in = '0;
    logic [VW-1:0] value_in = '0;
    logic          op_done;
    logic          op_error;
    logic [VW-1:0] value_out;
    logic [CW-1:0] probe_count;
    logic [OW-1:0] occupancy;
`ifdef HASH_TABLE_STATS_EN
    logic [CW-1:0] max_probe_seen;
    logic [15:0]   error_cnt;
`endif
    fsm_state_e    dbg_state;

    hash_table_lp #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TOTAL_ENTRY(TE), .MAX_PROBE(MP),
        .HASH_ALGORITHM("MODULUS")
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_sel(op_sel), .key_in(key_in), .value_in(value_in),
        .op_done(op_done), .op_error(op_error), .value_out(value_out),
        .probe_count(probe_count), .occupancy(occupancy),
`ifdef HASH_TABLE_STATS_EN
        .max_probe_seen(max_probe_seen), .error_cnt(error_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_st  [TE];   // 0 empty, 1 valid, 2 tombstone
    logic [KW-1:0] m_key [TE];
    logic [VW-1:0] m_val [TE];
    int            m_occ  = 0;
    int            m_errs = 0;
    int            m_maxp = 0;

    task automatic model_reset();
        for (int i = 0; i < TE; i++) begin
            m_st[i] = 0; m_key[i] = '0; m_val[i] = '0;
        end
        m_occ = 0; m_errs = 0; m_maxp = 0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                            output logic err, output logic [VW-1:0] vo, output int pc);
        int home, cand, hit_i, i;
        err = 1'b0; vo = '0; pc = 0;
        if (op == 2'b11) begin
            for (int j = 0; j < TE; j++) m_st[j] = 0;
            m_occ = 0; m_errs = 0; m_maxp = 0;
            return;
        end
        home = int'(k % TE); cand = -1; hit_i = -1;
        for (int p = 0; p < MP; p++) begin
            i  = (home + p) % TE;
            pc = p + 1;
            if (m_st[i] == 1 && m_key[i] == k) begin hit_i = i; break; end
            if (m_st[i] != 1 && cand < 0) cand = i;
            if (m_st[i] == 0) break;
        end
        case (op)
            2'b00: if (hit_i >= 0) m_val[hit_i] = v;
                   else if (cand >= 0) begin
                       m_st[cand] = 1; m_key[cand] = k; m_val[cand] = v; m_occ++;
                   end else err = 1'b1;
            2'b01: if (hit_i >= 0) begin
                       m_st[hit_i] = 2; m_key[hit_i] = '0; m_val[hit_i] = '0; m_occ--;
                   end else err = 1'b1;
            default: if (hit_i >= 0) vo = m_val[hit_i]; else err = 1'b1;
        endcase
        if (err && m_errs < 16'hFFFF) m_errs++;
        if (pc > m_maxp) m_maxp = pc;
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            acc_cyc = 0;
    logic          got_err;
    logic [VW-1:0] got_val;
    logic [CW-1:0] got_pc;
    int            got_lat;

    always @(negedge clk) begin
        if (!rst) begin
            if (op_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op_done", 64'd1, 64'd0);
                end else begin
                    logic          e_err;
                    logic [VW-1:0] e_val;
                    logic [CW-1:0] e_pc;
                    logic [OW-1:0] e_occ;
                    logic [7:0]    e_lat;
                    {e_err, e_val, e_pc, e_occ, e_lat} = exp_q.pop_front();
                    got_err = op_error;
                    got_val = value_out;
                    got_pc  = probe_count;
                    got_lat = cyc - acc_cyc;
                    chk("op_error",    64'(op_error),    64'(e_err));
                    chk("value_out",   64'(value_out),   64'(e_val));
                    chk("probe_count", 64'(probe_count), 64'(e_pc));
                    chk("occupancy",   64'(occupancy),   64'(e_occ));
                    chk("latency",     64'(got_lat),     64'(e_lat));
                end
            end else begin
                chk("op_error_idle", 64'(op_error), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk(name, 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v);
        logic          e_err;
        logic [VW-1:0] e_vo;
        int            e_pc, e_lat;
        @(negedge clk);
        wait_ready("ready_before_op");
        op_valid = 1'b1; op_sel = op; key_in = k; value_in = v;
        acc_cyc  = cyc;
        model_op(op, k, v, e_err, e_vo, e_pc);
        e_lat = (op == 2'b11) ? 1 : e_pc + 2;
        exp_q.push_back({e_err, e_vo, CW'(e_pc), OW'(m_occ), 8'(e_lat)});
        @(negedge clk);
        op_valid = 1'b0;
        op_sel   = 2'($urandom_range(0, 3));
        key_in   = $urandom;
        value_in = $urandom;
        wait_ready("ready_after_op");
        if (exp_q.size() != 0) begin
            chk("op_done_missing", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_op_ready",    64'(op_ready),    64'd1);
        chk("rst_op_done",     64'(op_done),     64'd0);
        chk("rst_op_error",    64'(op_error),    64'd0);
        chk("rst_value_out",   64'(value_out),   64'd0);
        chk("rst_probe_count", 64'(probe_count), 64'd0);
        chk("rst_occupancy",   64'(occupancy),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single insert and search
        do_op(2'b00, 3, 32'hAA);
        chk("t1_ins_err", 64'(got_err), 64'd0);
        chk("t1_ins_pc",  64'(got_pc),  64'd1);
        chk("t1_ins_lat", 64'(got_lat), 64'd3);
        chk("t1_ins_occ", 64'(occupancy), 64'd1);
        do_op(2'b10, 3, 0);
        chk("t1_srch_val", 64'(got_val), 64'hAA);
        chk("t1_srch_pc",  64'(got_pc),  64'd1);

        // collision chain from home slot 1
        do_op(2'b11, 0, 0);
        chk("t2_clr_lat", 64'(got_lat), 64'd1);
        do_op(2'b00, 1, 32'h11);  chk("t2_pc1", 64'(got_pc), 64'd1);
        do_op(2'b00, 9, 32'h99);  chk("t2_pc2", 64'(got_pc), 64'd2);
        do_op(2'b00, 17, 32'h17); chk("t2_pc3", 64'(got_pc), 64'd3);
        do_op(2'b10, 17, 0);
        chk("t2_srch_val", 64'(got_val), 64'h17);
        chk("t2_srch_pc",  64'(got_pc),  64'd3);
        chk("t2_srch_lat", 64'(got_lat), 64'd5);

        // tombstone handling
        do_op(2'b01, 9, 0);       chk("t3_del_occ", 64'(occupancy), 64'd2);
        do_op(2'b10, 17, 0);      chk("t3_srch_pc", 64'(got_pc), 64'd3);
        chk("t3_srch_err", 64'(got_err), 64'd0);
        do_op(2'b00, 25, 32'h25);
        chk("t3_ins_pc",  64'(got_pc),    64'd4);
        chk("t3_ins_occ", 64'(occupancy), 64'd3);
        do_op(2'b10, 9, 0);       chk("t3_miss_err", 64'(got_err), 64'd1);

        // update in place
        do_op(2'b00, 1, 32'h55);
        chk("t4_upd_err", 64'(got_err), 64'd0);
        chk("t4_upd_occ", 64'(occupancy), 64'd3);
        do_op(2'b10, 1, 0);       chk("t4_srch_val", 64'(got_val), 64'h55);

        // full table, bounded miss, wrap-around
        do_op(2'b11, 0, 0);
        do_op(2'b00, 7, 32'h107);
        do_op(2'b00, 15, 32'h115); chk("t5_wrap_ins_pc", 64'(got_pc), 64'd2);
        for (int k = 1; k <= 6; k++) do_op(2'b00, k, 32'h100 + k);
        chk("t5_full_occ", 64'(occupancy), 64'd8);
        do_op(2'b00, 40, 32'h40);
        chk("t5_full_err", 64'(got_err), 64'd1);
        chk("t5_full_pc",  64'(got_pc),  64'd8);
        chk("t5_full_occ2", 64'(occupancy), 64'd8);
        do_op(2'b10, 48, 0);
        chk("t5_absent_err", 64'(got_err), 64'd1);
        chk("t5_absent_pc",  64'(got_pc),  64'd8);
        do_op(2'b10, 15, 0);
        chk("t5_wrap_val", 64'(got_val), 64'h115);
        chk("t5_wrap_pc",  64'(got_pc),  64'd2);
`ifdef HASH_TABLE_STATS_EN
        chk("stats_max_probe", 64'(max_probe_seen), 64'(m_maxp));
        chk("stats_error_cnt", 64'(error_cnt),      64'(m_errs));
`endif

        // clear and reset abort
        do_op(2'b11, 0, 0);
        chk("t6_clr_lat", 64'(got_lat), 64'd1);
        chk("t6_clr_occ", 64'(occupancy), 64'd0);
        do_op(2'b10, 3, 0);       chk("t6_srch_err", 64'(got_err), 64'd1);
        for (int k = 0; k < 4; k++) do_op(2'b00, 1 + 8 * k, 32'h200 + k);
        @(negedge clk);
        op_valid = 1'b1; op_sel = 2'b10; key_in = 33; value_in = 0;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_op_ready",  64'(op_ready),  64'd1);
        chk("abort_occupancy", 64'(occupancy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        begin
            int spurious = 0;
            repeat (10) begin
                @(negedge clk);
                if (op_done) spurious++;
            end
            chk("abort_no_done", 64'(spurious), 64'd0);
        end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 99);
            logic [1:0] op;
            if (r < 45)      op = 2'b00;
            else if (r < 65) op = 2'b01;
            else if (r < 97) op = 2'b10;
            else             op = 2'b11;
            do_op(op, KW'($urandom_range(0, 23)), $urandom);
        end
        @(negedge clk);
        chk("final_occupancy", 64'(occupancy), 64'(m_occ));
`ifdef HASH_TABLE_STATS_EN
        chk("final_max_probe", 64'(max_probe_seen), 64'(m_maxp));
        chk("final_error_cnt", 64'(error_cnt),      64'(m_errs));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
